// File: rtl/thread_issue_scheduler_if.sv
// Issue/feedback bundle between the barrel-thread scheduler and its control path.
// The master drives enables, fault clears and I/O readiness; the slave is the scheduler.
interface thread_issue_scheduler_if #(
  parameter int THREAD_COUNT      = 8,
  parameter int THREAD_ADDR_WIDTH = 3
);
  logic [THREAD_COUNT-1:0]      thread_enable;
  logic [THREAD_COUNT-1:0]      fault_clear;
  logic                         io_ready;
  logic [THREAD_ADDR_WIDTH-1:0] issue_thread;
  logic                         issue_valid;
  logic                         pc_hold;
  logic [THREAD_ADDR_WIDTH-1:0] pc_hold_thread;
  logic [THREAD_COUNT-1:0]      fault_mask;
  logic                         busy;

  modport master (
    output thread_enable, fault_clear, io_ready,
    input  issue_thread, issue_valid, pc_hold, pc_hold_thread, fault_mask, busy
  );

  modport slave (
    input  thread_enable, fault_clear, io_ready,
    output issue_thread, issue_valid, pc_hold, pc_hold_thread, fault_mask, busy
  );
endinterface

// File: rtl/thread_issue_scheduler.sv
// Barrel-thread issue scheduler: fixed round-robin slot, delayed I/O readiness feedback,
// PC hold on not-ready accesses and fault parking of threads that stall repeatedly.
module thread_issue_scheduler #(
  parameter int THREAD_COUNT      = 8,
  parameter int THREAD_ADDR_WIDTH = 3,
  parameter int FEEDBACK_DELAY    = 4,
  parameter int STALL_LIMIT       = 16,
  parameter int STALL_COUNT_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  thread_issue_scheduler_if.slave  bus
);

  typedef struct packed {
    logic [THREAD_ADDR_WIDTH-1:0] thread;
    logic                         valid;
  } fb_entry_t;

  localparam logic [STALL_COUNT_WIDTH-1:0] STALL_LIMIT_C = STALL_COUNT_WIDTH'(STALL_LIMIT);
  localparam logic [STALL_COUNT_WIDTH-1:0] STALL_MAX_C   = '1;

  logic [THREAD_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  fb_entry_t                    line_q [FEEDBACK_DELAY];
  logic [THREAD_COUNT-1:0]      fault_mask_q, fault_mask_d;
  logic [STALL_COUNT_WIDTH-1:0] stall_q [THREAD_COUNT];
  logic [STALL_COUNT_WIDTH-1:0] stall_d [THREAD_COUNT];

  fb_entry_t                    tail;
  logic                         issue_valid;
  logic                         busy;
  logic [STALL_COUNT_WIDTH-1:0] stall_inc;

  assign tail        = line_q[FEEDBACK_DELAY-1];
  assign issue_valid = bus.thread_enable[ptr_q] & ~fault_mask_q[ptr_q];
  // Thread count is a power of two, so the natural wrap of the adder is the modulo.
  assign ptr_d       = ptr_q + THREAD_ADDR_WIDTH'(1);

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < FEEDBACK_DELAY; i++) begin
      busy = busy | line_q[i].valid;
    end
  end

  assign stall_inc = (stall_q[tail.thread] == STALL_MAX_C) ? STALL_MAX_C
                                                           : stall_q[tail.thread] + STALL_COUNT_WIDTH'(1);

  // NOTE: every variable gets its default first so no path leaves a latch behind.
  always_comb begin
    fault_mask_d = fault_mask_q;
    stall_d      = stall_q;
    for (int t = 0; t < THREAD_COUNT; t++) begin
      if (bus.fault_clear[t]) begin
        fault_mask_d[t] = 1'b0;
        stall_d[t]      = '0;
      end
    end
    // Feedback is applied after the clears so a fault set for the same thread wins.
    if (tail.valid) begin
      if (bus.io_ready) begin
        stall_d[tail.thread] = '0;
      end else if (stall_inc >= STALL_LIMIT_C && !fault_mask_q[tail.thread]) begin
        fault_mask_d[tail.thread] = 1'b1;
        stall_d[tail.thread]      = '0;
      end else if (!bus.fault_clear[tail.thread]) begin
        stall_d[tail.thread] = stall_inc;
      end
    end
  end

  // NOTE: the per-thread counters are reset too; a stale count would fault a thread early.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q        <= '0;
      fault_mask_q <= '0;
      for (int i = 0; i < FEEDBACK_DELAY; i++) begin
        line_q[i] <= '0;
      end
      for (int t = 0; t < THREAD_COUNT; t++) begin
        stall_q[t] <= '0;
      end
    end else begin
      ptr_q        <= ptr_d;
      fault_mask_q <= fault_mask_d;
      line_q[0]    <= '{thread: ptr_q, valid: issue_valid};
      for (int i = 1; i < FEEDBACK_DELAY; i++) begin
        line_q[i] <= line_q[i-1];
      end
      stall_q <= stall_d;
    end
  end

  assign bus.issue_thread   = ptr_q;
  assign bus.issue_valid    = issue_valid;
  assign bus.pc_hold        = tail.valid & ~bus.io_ready;
  assign bus.pc_hold_thread = tail.thread;
  assign bus.fault_mask     = fault_mask_q;
  assign bus.busy           = busy;

endmodule

// File: tb/tb_thread_issue_scheduler.sv
// Randomized bench for thread_issue_scheduler against a cycle-history reference model.
module tb_thread_issue_scheduler;
  localparam int TC = 8;
  localparam int AW = 3;
  localparam int FD = 4;
  localparam int SL = 3;
  localparam int SW = 8;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  thread_issue_scheduler_if #(.THREAD_COUNT(TC), .THREAD_ADDR_WIDTH(AW)) bus ();

  thread_issue_scheduler #(
    .THREAD_COUNT(TC), .THREAD_ADDR_WIDTH(AW), .FEEDBACK_DELAY(FD),
    .STALL_LIMIT(SL), .STALL_COUNT_WIDTH(SW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Model: cycles since reset, fault bits, stall counts and the slots issued in the last FD cycles.
  int m_cycle;
  bit m_fault [TC];
  int m_stall [TC];
  int q_thr [$];
  bit q_val [$];

  function automatic void model_reset();
    m_cycle = 0;
    for (int t = 0; t < TC; t++) begin
      m_fault[t] = 1'b0;
      m_stall[t] = 0;
    end
    q_thr.delete();
    q_val.delete();
    for (int i = 0; i < FD; i++) begin
      q_thr.push_back(0);
      q_val.push_back(1'b0);
    end
  endfunction

  function automatic logic [TC-1:0] model_mask();
    logic [TC-1:0] m;
    for (int t = 0; t < TC; t++) m[t] = m_fault[t];
    return m;
  endfunction

  task automatic step(input logic [TC-1:0] en, input logic [TC-1:0] clr, input bit rdy, input bit rst);
    int  ptr, tt, inc;
    bit  ev, tv, exp_busy;
    bit  nf [TC];
    int  ns [TC];
    @(negedge clock);
    bus.thread_enable = en;
    bus.fault_clear   = clr;
    bus.io_ready      = rdy;
    reset             = rst;
    #1;
    if (rst) begin
      model_reset();
      check("rst_issue_thread", 32'(bus.issue_thread), 0);
      check("rst_issue_valid",  32'(bus.issue_valid), 32'(en[0]));
      check("rst_pc_hold",      32'(bus.pc_hold), 0);
      check("rst_busy",         32'(bus.busy), 0);
      check("rst_fault_mask",   32'(bus.fault_mask), 0);
      return;
    end
    ptr = m_cycle % TC;
    ev  = en[ptr] && !m_fault[ptr];
    tt  = q_thr[0];
    tv  = q_val[0];
    exp_busy = 1'b0;
    foreach (q_val[i]) exp_busy |= q_val[i];
    check("issue_thread",   32'(bus.issue_thread), 32'(ptr));
    check("issue_valid",    32'(bus.issue_valid), 32'(ev));
    check("pc_hold",        32'(bus.pc_hold), 32'(tv && !rdy));
    check("pc_hold_thread", 32'(bus.pc_hold_thread), 32'(tt));
    check("fault_mask",     32'(bus.fault_mask), 32'(model_mask()));
    check("busy",           32'(bus.busy), 32'(exp_busy));

    for (int t = 0; t < TC; t++) begin
      nf[t] = clr[t] ? 1'b0 : m_fault[t];
      ns[t] = clr[t] ? 0 : m_stall[t];
    end
    if (tv) begin
      if (rdy) begin
        ns[tt] = 0;
      end else begin
        inc = (m_stall[tt] + 1 > 255) ? 255 : m_stall[tt] + 1;
        if (inc >= SL && !m_fault[tt]) begin
          nf[tt] = 1'b1;
          ns[tt] = 0;
        end else if (!clr[tt]) begin
          ns[tt] = inc;
        end
      end
    end
    for (int t = 0; t < TC; t++) begin
      m_fault[t] = nf[t];
      m_stall[t] = ns[t];
    end
    void'(q_thr.pop_front());
    void'(q_val.pop_front());
    q_thr.push_back(ptr);
    q_val.push_back(ev);
    m_cycle++;
  endtask

  function automatic logic [TC-1:0] rand_clear(int one_in);
    logic [TC-1:0] c;
    c = '0;
    if ($urandom_range(one_in - 1) == 0) c[$urandom_range(TC - 1)] = 1'b1;
    return c;
  endfunction

  initial begin
    logic [TC-1:0] en, clr;
    bit            rdy;
    int            phase, rst_left;
    bus.thread_enable = '1;
    bus.fault_clear   = '0;
    bus.io_ready      = 1'b1;
    reset             = 1'b1;
    rst_left          = 0;
    model_reset();
    step(8'hFF, '0, 1'b1, 1'b1);
    step(8'hFF, '0, 1'b1, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      phase = i / 500;
      case (phase)
        0: begin en = 8'hFF; clr = '0; rdy = 1'b1; end
        1: begin en = 8'h05; clr = '0; rdy = ($urandom_range(3) != 0); end
        2: begin en = TC'($urandom); clr = rand_clear(16); rdy = ($urandom_range(9) < 4); end
        3: begin en = TC'($urandom); clr = ($urandom_range(3) == 0) ? TC'($urandom) : '0;
                 rdy = ($urandom_range(9) < 3); end
        4: begin en = TC'($urandom) | TC'($urandom); clr = rand_clear(8); rdy = ($urandom_range(1) == 0); end
        default: begin en = TC'($urandom); clr = TC'($urandom) & TC'($urandom) & TC'($urandom);
                       rdy = $urandom_range(1); end
      endcase
      if (phase >= 4 && rst_left == 0 && $urandom_range(63) == 0) rst_left = $urandom_range(3, 1);
      if (rst_left > 0) begin
        rst_left--;
        step(en, clr, 1'b0, 1'b1);
      end else begin
        step(en, clr, rdy, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
